// File: rtl/alu_pkg.sv
// Shared opcode constants, default widths and command bundle for the ALU issue path.
// Used by alu_sync_fifo and alu_issue_queue.
package alu_pkg;

    localparam int ALU_WIDTH  = 8;
    localparam int ALU_OPCODE = 3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_RSVD = 3'b101;
    localparam logic [2:0] OP_SHL1 = 3'b110;
    localparam logic [2:0] OP_SHL2 = 3'b111;

    typedef struct packed {
        logic [ALU_WIDTH-1:0]  data1;
        logic [ALU_WIDTH-1:0]  data2;
        logic [ALU_OPCODE-1:0] op;
    } alu_cmd_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op != OP_RSVD;
    endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Generic DEPTH x DW synchronous FIFO with count-based full/empty.
// Caller guarantees no push when full and no pop when empty.
module alu_sync_fifo
    import alu_pkg::*;
#(
    parameter int DW    = 2 * ALU_WIDTH + ALU_OPCODE,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DW-1:0]              i_wdata,
    output logic [DW-1:0]              o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage has no reset; contents are only observed when count != 0.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/alu_issue_queue.sv
// Issue queue in front of the 8-bit ALU: filters opcode 101, holds last output.
// Optional same-cycle empty-queue bypass enabled by macro ALU_ISSUE_BYPASS_EN.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int OPCODE = ALU_OPCODE,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data1,
    input  logic [WIDTH-1:0]           in_data2,
    input  logic [OPCODE-1:0]          in_op,
    output logic [WIDTH-1:0]           alu_data_in1,
    output logic [WIDTH-1:0]           alu_data_in2,
    output logic [OPCODE-1:0]          alu_op_code,
    output logic                       alu_valid_data,
    input  logic                       alu_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_illegal_op,
    input  logic                       err_clear
);

    localparam int DW = 2 * WIDTH + OPCODE;
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] w_in_cmd;
    logic [DW-1:0] w_head;
    logic [DW-1:0] w_out;
    logic [DW-1:0] r_last;
    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_legal;
    logic          w_accept;
    logic          w_byp;
    logic          w_byp_take;
    logic          w_push;
    logic          w_pop;
    logic          r_err;

    assign w_in_cmd = {in_data1, in_data2, in_op};
    assign w_empty  = (w_count == '0);
    assign in_ready = (w_count != CW'(DEPTH));
    assign w_legal  = (in_op != OPCODE'(OP_RSVD));
    assign w_accept = in_valid && in_ready;

`ifdef ALU_ISSUE_BYPASS_EN
    assign w_byp = w_empty && in_valid && w_legal;
`else
    assign w_byp = 1'b0;
`endif

    assign w_byp_take = w_byp && alu_ready;
    assign w_push     = w_accept && w_legal && !w_byp_take;
    assign w_pop      = !w_empty && alu_ready;

    alu_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_in_cmd),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    // r_last keeps the ALU inputs stable (and never X) while the queue is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_last <= w_head;
            end else if (w_byp_take) begin
                r_last <= w_in_cmd;
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end else if (err_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign w_out = w_byp ? w_in_cmd : (w_empty ? r_last : w_head);

    assign alu_data_in1   = w_out[DW-1 -: WIDTH];
    assign alu_data_in2   = w_out[OPCODE +: WIDTH];
    assign alu_op_code    = w_out[OPCODE-1:0];
    assign alu_valid_data = !w_empty || w_byp;
    assign count          = w_count;
    assign err_illegal_op = r_err;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue.
// Adapts the bypass-related expectations when ALU_ISSUE_BYPASS_EN is defined.
module tb_alu_issue_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data1 = '0;
    logic [7:0] in_data2 = '0;
    logic [2:0] in_op = '0;
    logic [7:0] alu_data_in1;
    logic [7:0] alu_data_in2;
    logic [2:0] alu_op_code;
    logic       alu_valid_data;
    logic       alu_ready = 1'b0;
    logic [2:0] count;
    logic       err_illegal_op;
    logic       err_clear = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_queue #(.WIDTH(8), .OPCODE(3), .DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data1       (in_data1),
        .in_data2       (in_data2),
        .in_op          (in_op),
        .alu_data_in1   (alu_data_in1),
        .alu_data_in2   (alu_data_in2),
        .alu_op_code    (alu_op_code),
        .alu_valid_data (alu_valid_data),
        .alu_ready      (alu_ready),
        .count          (count),
        .err_illegal_op (err_illegal_op),
        .err_clear      (err_clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op);
        in_valid = v;
        in_data1 = a;
        in_data2 = b;
        in_op    = op;
    endtask

    logic [2:0] ops [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                             3'd6, 3'd7, 3'd0, 3'd1, 3'd2};

    initial begin
        // Reset state
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(alu_valid_data), 0);
        chk("rst_d1", 32'(alu_data_in1), 0);
        chk("rst_d2", 32'(alu_data_in2), 0);
        chk("rst_op", 32'(alu_op_code), 0);
        chk("rst_err", 32'(err_illegal_op), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push, one-cycle latency
        drive(1'b1, 8'h12, 8'h34, 3'b000);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        chk("p1_valid", 32'(alu_valid_data), 1);
        chk("p1_d1", 32'(alu_data_in1), 32'h12);
        chk("p1_d2", 32'(alu_data_in2), 32'h34);
        chk("p1_op", 32'(alu_op_code), 0);
        chk("p1_count", 32'(count), 1);
        alu_ready = 1'b1;
        tick();
        alu_ready = 1'b0;
        chk("p1_pop_count", 32'(count), 0);
        chk("p1_hold_d1", 32'(alu_data_in1), 32'h12);

        // Fill to DEPTH, reject a fifth, drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h20 + i), 8'(8'h30 + i), 3'(i));
            tick();
        end
        chk("full_count", 32'(count), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        drive(1'b1, 8'h99, 8'h98, 3'b000);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        chk("full_reject_count", 32'(count), 4);
        chk("full_reject_head", 32'(alu_data_in1), 32'h20);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_d1_%0d", i), 32'(alu_data_in1), 32'h20 + i);
            chk($sformatf("drain_op_%0d", i), 32'(alu_op_code), i);
            alu_ready = 1'b1;
            tick();
        end
        chk("drain_count", 32'(count), 0);
        chk("drain_valid", 32'(alu_valid_data), 0);
        chk("drain_hold_d1", 32'(alu_data_in1), 32'h23);
        chk("drain_hold_d2", 32'(alu_data_in2), 32'h33);
        chk("drain_hold_op", 32'(alu_op_code), 3);
        tick();
        chk("empty_ready_count", 32'(count), 0);
        chk("empty_ready_valid", 32'(alu_valid_data), 0);

        // Streaming with wrap over 10 commands
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 8'(8'h40 + k), 8'(8'h50 + k), ops[k]);
            tick();
`ifdef ALU_ISSUE_BYPASS_EN
            chk($sformatf("stream_count_%0d", k), 32'(count), 0);
`else
            chk($sformatf("stream_count_%0d", k), 32'(count), 1);
`endif
            chk($sformatf("stream_d1_%0d", k), 32'(alu_data_in1), 32'h40 + k);
            chk($sformatf("stream_op_%0d", k), 32'(alu_op_code), 32'(ops[k]));
        end
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        tick();
        alu_ready = 1'b0;
        chk("stream_end_count", 32'(count), 0);
        chk("stream_end_valid", 32'(alu_valid_data), 0);
        chk("stream_end_d1", 32'(alu_data_in1), 32'h49);

        // Reserved opcode filter and sticky error
        drive(1'b1, 8'hFF, 8'h01, 3'b101);
        #1;
        chk("rsvd_in_ready", 32'(in_ready), 1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        chk("rsvd_count", 32'(count), 0);
        chk("rsvd_valid", 32'(alu_valid_data), 0);
        chk("rsvd_err", 32'(err_illegal_op), 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared", 32'(err_illegal_op), 0);
        drive(1'b1, 8'hFF, 8'h01, 3'b101);
        err_clear = 1'b1;
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        chk("err_set_beats_clear", 32'(err_illegal_op), 1);
        tick();
        err_clear = 1'b0;
        chk("err_cleared2", 32'(err_illegal_op), 0);

        // Async reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h60 + i), 8'h00, 3'b010);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        chk("pre_rst_count", 32'(count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_valid", 32'(alu_valid_data), 0);
        chk("async_rst_d1", 32'(alu_data_in1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h70, 8'h71, 3'b011);
        tick();
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        chk("post_rst_count", 32'(count), 1);
        chk("post_rst_d1", 32'(alu_data_in1), 32'h70);
        alu_ready = 1'b1;
        tick();
        alu_ready = 1'b0;
        chk("post_rst_drain", 32'(count), 0);

        // Empty queue with command and alu_ready in the same cycle
        drive(1'b1, 8'h05, 8'h03, 3'b001);
        alu_ready = 1'b1;
        #1;
`ifdef ALU_ISSUE_BYPASS_EN
        chk("byp_valid", 32'(alu_valid_data), 1);
        chk("byp_d1", 32'(alu_data_in1), 32'h05);
        chk("byp_d2", 32'(alu_data_in2), 32'h03);
        chk("byp_op", 32'(alu_op_code), 1);
        tick();
        chk("byp_count", 32'(count), 0);
`else
        chk("nobyp_valid", 32'(alu_valid_data), 0);
        chk("nobyp_d1", 32'(alu_data_in1), 32'h70);
        tick();
        chk("nobyp_count", 32'(count), 1);
        chk("nobyp_d1_next", 32'(alu_data_in1), 32'h05);
`endif
        drive(1'b0, 8'h00, 8'h00, 3'b000);
        tick();
        alu_ready = 1'b0;
        chk("final_count", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
